// File: rtl/mont_bitlen_scan_pkg.sv
// Shared types and constants for the Montgomery bit-length scanner.
package mont_bitlen_scan_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } scan_state_e;

    localparam logic MODE_MSB = 1'b0;
    localparam logic MODE_LSB = 1'b1;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >>> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mont_bitlen_scan_prienc.sv
// Chunk-wide priority encoder: index of the highest (MSB dir) or lowest (LSB dir) set bit.
module mont_bitlen_scan_prienc
    import mont_bitlen_scan_pkg::*;
#(
    parameter int CHUNK = 64,
    parameter int IW    = clog2(CHUNK)
) (
    input  logic [CHUNK-1:0] i_vec,
    input  logic             i_dir,
    output logic [IW-1:0]    o_idx,
    output logic             o_any
);

    // Scan order makes the last hit win: ascending for highest, descending for lowest.
    always_comb begin
        o_idx = {IW{1'b0}};
        o_any = |i_vec;
        if (i_dir == MODE_MSB) begin
            for (int i = 0; i < CHUNK; i++) begin
                if (i_vec[i]) begin
                    o_idx = IW'(i);
                end else begin
                    o_idx = o_idx;
                end
            end
        end else begin
            for (int i = CHUNK - 1; i >= 0; i--) begin
                if (i_vec[i]) begin
                    o_idx = IW'(i);
                end else begin
                    o_idx = o_idx;
                end
            end
        end
    end

endmodule

// File: rtl/mont_bitlen_scan.sv
// Bit-length / bit-position scanner: walks the operand one chunk per cycle and
// stops at the first non-zero chunk, reporting the extreme set-bit index.
module mont_bitlen_scan
    import mont_bitlen_scan_pkg::*;
#(
    parameter int WIDTH = 2048,
    parameter int CHUNK = 64,
    parameter int IDXW  = clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] n,
    output logic             busy,
    output logic             done,
    output logic [IDXW-1:0]  result,
    output logic             zero
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int PTRW   = (NCHUNK > 1) ? clog2(NCHUNK) : 1;
    localparam int CW     = clog2(CHUNK);
    localparam int BW     = PTRW + CW;

    scan_state_e      r_state;
    scan_state_e      w_next_state;
    logic [WIDTH-1:0] r_op;
    logic             r_mode;
    logic [PTRW-1:0]  r_ptr;
    logic             r_busy;
    logic             r_done;
    logic [IDXW-1:0]  r_result;
    logic             r_zero;

    logic [BW-1:0]    w_base;
    logic [CHUNK-1:0] w_chunk;
    logic [CW-1:0]    w_idx;
    logic             w_any;
    logic             w_last;
    logic             w_accept;

    // Chunk base is ptr*CHUNK as a shift; the operand itself never moves.
    assign w_base  = {r_ptr, {CW{1'b0}}};
    assign w_chunk = r_op[w_base +: CHUNK];

    mont_bitlen_scan_prienc #(
        .CHUNK (CHUNK),
        .IW    (CW)
    ) u_prienc (
        .i_vec (w_chunk),
        .i_dir (r_mode),
        .o_idx (w_idx),
        .o_any (w_any)
    );

    // Decode acceptance and last-chunk conditions for the current pointer.
    always_comb begin
        w_accept = (r_state == ST_IDLE) && start;
        if (r_mode == MODE_MSB) begin
            w_last = (r_ptr == {PTRW{1'b0}});
        end else begin
            w_last = (r_ptr == PTRW'(NCHUNK - 1));
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next_state = ST_SCAN;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (w_any || w_last) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_state = ST_SCAN;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Operand capture, pointer walk and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_op     <= {WIDTH{1'b0}};
            r_mode   <= MODE_MSB;
            r_ptr    <= {PTRW{1'b0}};
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= {IDXW{1'b0}};
            r_zero   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (w_accept) begin
                        r_op     <= n;
                        r_mode   <= mode;
                        r_ptr    <= (mode == MODE_MSB) ? PTRW'(NCHUNK - 1) : {PTRW{1'b0}};
                        r_busy   <= 1'b1;
                        r_result <= {IDXW{1'b0}};
                        r_zero   <= 1'b0;
                    end else begin
                        r_busy <= 1'b0;
                    end
                end
                ST_SCAN: begin
                    if (w_any) begin
                        r_result <= IDXW'(w_base | {{PTRW{1'b0}}, w_idx});
                        r_zero   <= 1'b0;
                        r_done   <= 1'b1;
                        r_busy   <= 1'b0;
                    end else if (w_last) begin
                        r_result <= {IDXW{1'b0}};
                        r_zero   <= 1'b1;
                        r_done   <= 1'b1;
                        r_busy   <= 1'b0;
                    end else begin
                        r_ptr  <= (r_mode == MODE_MSB) ? (r_ptr - PTRW'(1)) : (r_ptr + PTRW'(1));
                        r_done <= 1'b0;
                    end
                end
                default: begin
                    r_busy <= 1'b0;
                    r_done <= 1'b0;
                end
            endcase
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign result = r_result;
    assign zero   = r_zero;

endmodule

// File: tb/tb_mont_bitlen_scan.sv
// Self-checking bench for mont_bitlen_scan: directed table, random vs reference model, corner sequences.
module tb_mont_bitlen_scan;

    localparam int WIDTH  = 2048;
    localparam int CHUNK  = 64;
    localparam int IDXW   = 11;
    localparam int NCHUNK = WIDTH / CHUNK;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             mode;
    logic [WIDTH-1:0] n;
    logic             busy;
    logic             done;
    logic [IDXW-1:0]  result;
    logic             zero;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [WIDTH-1:0] n;
        logic             mode;
        int               res;
        bit               z;
        int               m;
    } vec_t;

    vec_t tbl [8];

    always #5 clk = ~clk;

    mont_bitlen_scan #(
        .WIDTH (WIDTH),
        .CHUNK (CHUNK),
        .IDXW  (IDXW)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .mode   (mode),
        .n      (n),
        .busy   (busy),
        .done   (done),
        .result (result),
        .zero   (zero)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Reference: scan every bit of the operand, then derive the chunk count from the index.
    task automatic ref_model(input logic [WIDTH-1:0] v, input logic md,
                             output int res, output bit z, output int m);
        z   = (v == {WIDTH{1'b0}});
        res = 0;
        m   = NCHUNK;
        if (!z) begin
            if (md == 1'b0) begin
                for (int i = 0; i < WIDTH; i++) if (v[i]) res = i;
                m = NCHUNK - res / CHUNK;
            end else begin
                for (int i = WIDTH - 1; i >= 0; i--) if (v[i]) res = i;
                m = res / CHUNK + 1;
            end
        end
    endtask

    function automatic logic [WIDTH-1:0] rand_word();
        logic [WIDTH-1:0] v;
        for (int i = 0; i < WIDTH / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic run_op(input string name, input logic [WIDTH-1:0] v, input logic md,
                          input int exp_res, input bit exp_z, input int exp_m, input bit poke);
        int  got_m;
        bit  busy_ok;
        int  k;
        @(negedge clk);
        n     = v;
        mode  = md;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        n     = rand_word();
        mode  = ~md;
        check({name, "_busy_accept"}, busy, 1'b1);
        check({name, "_clear_accept"}, {result, zero}, 64'd0);
        got_m   = 0;
        busy_ok = 1'b1;
        k       = 0;
        while (got_m == 0 && k < NCHUNK + 4) begin
            @(posedge clk);
            #1;
            k++;
            if (done) begin
                got_m = k;
            end else begin
                if (!busy) busy_ok = 1'b0;
                if (poke && k == 5) begin
                    start = 1'b1;
                    n     = ~v;
                    mode  = ~md;
                end
                if (poke && k == 7) start = 1'b0;
            end
        end
        check({name, "_done_seen"}, (got_m != 0), 1'b1);
        check({name, "_latency"}, got_m, exp_m);
        check({name, "_busy_span"}, busy_ok, 1'b1);
        check({name, "_busy_at_done"}, busy, 1'b0);
        check({name, "_result"}, result, exp_res);
        check({name, "_zero"}, zero, exp_z);
        @(posedge clk);
        #1;
        check({name, "_done_pulse"}, done, 1'b0);
        check({name, "_hold"}, {result, zero}, {exp_res[IDXW-1:0], exp_z});
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [WIDTH-1:0] v_one, v_top, v_two, v;
        int               e_res, e_m, sel, t;
        bit               e_z;

        v_one = {WIDTH{1'b0}}; v_one[0] = 1'b1;
        v_top = {WIDTH{1'b0}}; v_top[WIDTH-1] = 1'b1;
        v_two = {WIDTH{1'b0}}; v_two[1000] = 1'b1; v_two[4] = 1'b1;
        tbl[0] = '{v_one, 1'b0, 0, 1'b0, 32};
        tbl[1] = '{v_top, 1'b0, 2047, 1'b0, 1};
        tbl[2] = '{v_top, 1'b1, 2047, 1'b0, 32};
        tbl[3] = '{{WIDTH{1'b0}}, 1'b0, 0, 1'b1, 32};
        tbl[4] = '{{WIDTH{1'b0}}, 1'b1, 0, 1'b1, 32};
        tbl[5] = '{v_two, 1'b0, 1000, 1'b0, 17};
        tbl[6] = '{v_two, 1'b1, 4, 1'b0, 1};
        tbl[7] = '{v_one, 1'b1, 0, 1'b0, 1};

        rst   = 1'b0;
        start = 1'b0;
        mode  = 1'b0;
        n     = {WIDTH{1'b0}};
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {busy, done, result, zero}, 64'd0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_op($sformatf("tbl%0d", i), tbl[i].n, tbl[i].mode, tbl[i].res, tbl[i].z, tbl[i].m, 1'b0);
        end

        for (int i = 0; i < 40; i++) begin
            sel = $urandom_range(0, 3);
            v   = {WIDTH{1'b0}};
            case (sel)
                0: v = {WIDTH{1'b0}};
                1: v[$urandom_range(0, WIDTH - 1)] = 1'b1;
                2: for (int j = 0; j < 3; j++) v[$urandom_range(0, WIDTH - 1)] = 1'b1;
                default: v = rand_word();
            endcase
            ref_model(v, 1'($urandom_range(0, 1)), e_res, e_z, e_m);
            t = e_m;
            ref_model(v, 1'(i % 2), e_res, e_z, e_m);
            run_op($sformatf("rnd%0d", i), v, 1'(i % 2), e_res, e_z, e_m, 1'b0);
        end

        // start pulsed mid-scan with a different operand must be ignored
        run_op("ignore_busy", v_one, 1'b0, 0, 1'b0, 32, 1'b1);

        // start held high through done: second operation accepted on the done cycle
        @(negedge clk);
        n = v_top; mode = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        n = v_two; mode = 1'b1;
        @(posedge clk); #1;
        check("b2b_first_done", done, 1'b1);
        check("b2b_first_result", result, 2047);
        @(posedge clk); #1;
        start = 1'b0;
        check("b2b_second_accept", {busy, done, result, zero}, {1'b1, 1'b0, 11'd0, 1'b0});
        @(posedge clk); #1;
        check("b2b_second_done", done, 1'b1);
        check("b2b_second_result", result, 4);
        @(posedge clk); #1;
        check("b2b_no_rerun", {busy, done}, 2'b00);

        // asynchronous reset mid-scan aborts without a done
        @(negedge clk);
        n = v_one; mode = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check("pre_reset_busy", busy, 1'b1);
        rst = 1'b0;
        #1;
        check("mid_reset_outputs", {busy, done, result, zero}, 64'd0);
        @(posedge clk); #1;
        check("mid_reset_no_done", done, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("after_reset_idle", {busy, done}, 2'b00);
        run_op("post_reset", v_two, 1'b0, 1000, 1'b0, 17, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
